// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS sequencing controller with retired-instruction counter
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_JAL    = 4'd11,
    S_JR     = 4'd12, S_IMMEX  = 4'd13, S_IMMWB  = 4'd14, S_LUIWB  = 4'd15
  } state_t;

  state_t cur, nxt;

  // All outputs decode from cur, so the async reset clears them without a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur <= S_IDLE;
    else          cur <= nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

  assign state = cur;

  always_comb begin
    nxt        = cur;
    pc_write   = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 3'd0;
    alu_op     = 3'd0;
    pc_source  = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 3'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 3'd3;
        unique case (opcode)
          6'd0:                         nxt = (funct == 6'd8) ? S_JR : S_EXEC;
          6'd35, 6'd43:                 nxt = S_MEMADR;
          6'd4, 6'd5:                   nxt = S_BRANCH;
          6'd8, 6'd10, 6'd12, 6'd13,
          6'd14:                        nxt = S_IMMEX;
          6'd15:                        nxt = S_LUIWB;
          6'd2:                         nxt = S_JUMP;
          6'd3:                         nxt = S_JAL;
          default: begin
            nxt        = S_FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd2;
        nxt       = (opcode == 6'd35) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        ior_d      = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'd2;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'd1;
        pc_source  = 2'd1;
        pc_write   = ((opcode == 6'd4) & zero) | ((opcode == 6'd5) & ~zero);
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = 2'd3;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = (opcode == 6'd8 || opcode == 6'd10) ? 3'd2 : 3'd4;
        unique case (opcode)
          6'd10:   alu_op = 3'd6;
          6'd12:   alu_op = 3'd4;
          6'd13:   alu_op = 3'd3;
          6'd14:   alu_op = 3'd5;
          default: alu_op = 3'd0;
        endcase
        nxt = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_LUIWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd3;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencing controller for the MIPS CPU. It replaces the single-cycle `control` decode with a Moore/Mealy state machine that drives one shared ALU and one unified instruction/data memory over several cycles per instruction. It sits between the instruction register (opcode/funct), the ALU zero flag and the memory ready handshake on one side, and the datapath mux selects and write enables on the other. It also keeps a retired-instruction counter.

## Interface
- `CNT_W`, default 32, width of the retired-instruction counter.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; stable from the cycle after FETCH completes.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_write`  out  1  PC load enable.
- `ior_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each  strobes.
- `reg_dst`  out  2  write register select: 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg`  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC, 3 = lui value.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = rs.
- `alu_src_b`  out  3  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2, 4 = zero-extended imm.
- `alu_op`  out  3  to AluControlUint: 0 = add, 1 = sub, 2 = R-type, 3 = or, 4 = and, 5 = xor, 6 = slt.
- `pc_source`  out  2  next-PC select: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump address, 3 = rs.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `retired`  out  CNT_W  count of `instr_done` pulses since reset.
- `state`  out  4  current state encoding, for debug.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, JAL 11, JR 12, IMMEX 13, IMMWB 14, LUIWB 15.
- Any output not listed for a state is 0.
- **IDLE:** all outputs 0. Goes to FETCH on the next edge.
- **FETCH:** `mem_read`=1, `ior_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_source`=0.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- **DECODE:** `alu_src_a`=0, `alu_src_b`=3, `alu_op`=0, so the branch target lands in ALUOut. Next state by opcode:
  - 0 with funct 8 → JR; 0 otherwise → EXEC.
  - 35 and 43 → MEMADR.
  - 4 and 5 → BRANCH.
  - 8, 10, 12, 13, 14 → IMMEX.
  - 15 → LUIWB.
  - 2 → JUMP; 3 → JAL.
  - Any other opcode → FETCH, with `illegal`=1 and `instr_done`=1.
- **MEMADR:** `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Goes to MEMRD for opcode 35, MEMWR for 43.
- **MEMRD:** `mem_read`=1, `ior_d`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
- **MEMWR:** `mem_write`=1, `ior_d`=1. Holds until `mem_ready`; the write commits on the ready edge.
- **EXEC:** `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2. Goes to ALUWB.
- **ALUWB:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
- **BRANCH:** `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_source`=1.
  - `pc_write` = (opcode==4 & zero) | (opcode==5 & ~zero), combinational within the cycle.
- **IMMEX:** `alu_src_a`=1.
  - `alu_src_b`=2 for opcodes 8 and 10; 4 for opcodes 12, 13, 14.
  - `alu_op`: 8→0, 10→6, 12→4, 13→3, 14→5.
  - Goes to IMMWB.
- **IMMWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
- **LUIWB:** `reg_write`=1, `reg_dst`=0, `mem_to_reg`=3.
- **JUMP:** `pc_write`=1, `pc_source`=2.
- **JAL:** `pc_write`=1, `pc_source`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2. The PC already holds the return address PC+4 at this point.
- **JR:** `pc_write`=1, `pc_source`=3. `reg_write` stays 0.
- MEMWB, MEMWR (on its ready cycle), ALUWB, BRANCH, IMMWB, LUIWB, JUMP, JAL and JR assert `instr_done` and return to FETCH.
- `retired` increments on every `instr_done` cycle and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: asserting `reset_n`=0 forces state to IDLE and `retired` to 0 immediately, without waiting for a clock edge. All outputs go to 0 immediately, including in-flight `mem_write` and `reg_write`.
- After release: the first rising edge enters FETCH; there is no fetch in the release cycle.
- Latency with `mem_ready` held at 1, in cycles from FETCH entry to `instr_done`: R-type 4, lw 5, sw 4, addi/slti/andi/ori/xori 4, beq/bne 3, j/jal/jr 3, lui 3.
- Each low cycle of `mem_ready` during FETCH, MEMRD or MEMWR adds exactly one cycle.
- Strobes and selects stay constant while a state is stalled. `ir_write` and `pc_write` pulse exactly once per fetch.
- `opcode`, `funct` and `zero` are sampled combinationally. They must be valid from DECODE onward; `zero` must be valid in BRANCH.

## Test plan
- Reset mid-MEMWR: assert `reset_n`=0 with `mem_write`=1 → `mem_write` drops without a clock edge, `state`=0, `retired`=0. After release: IDLE, then FETCH.
- `add` (opcode 0, funct 32) with `mem_ready`=1 → states 1, 2, 7, 8. In state 8: `reg_write`=1, `reg_dst`=1. `instr_done` on cycle 4, then `retired`=1.
- `lw` with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total. `mem_read`=1 and `ior_d`=1 are held throughout the stall. MEMWB has `mem_to_reg`=1.
- `bne` (opcode 5) with `zero`=0 → `pc_write`=1, `pc_source`=1 in BRANCH. Repeat with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- `jal` → JAL state with `pc_write`=1, `reg_dst`=2, `mem_to_reg`=2. `jr` (funct 8) → `pc_source`=3, `reg_write`=0.
- `ori` → IMMEX with `alu_src_b`=4, `alu_op`=3. Opcode 63 → `illegal` pulses in DECODE and the next state is FETCH. With CNT_W=4, the 16th retired instruction wraps `retired` to 0.
